// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: accepts instruction words, fetches the memory operand,
// sequences the external combinational ALU and writes back ACC and the C/B flags.
module alu_exec_ctrl #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                INSTR_VALID,
    output logic                INSTR_READY,
    input  logic [AWIDTH+3:0]   INSTR,
    output logic                DONE,
    output logic [AWIDTH-1:0]   MEM_ADDR,
    output logic                MEM_RE,
    input  logic [DWIDTH-1:0]   MEM_RDATA,
    output logic                MEM_WE,
    output logic [DWIDTH-1:0]   MEM_WDATA,
    output logic [3:0]          ALU_INSTR,
    output logic [DWIDTH-1:0]   ALU_A,
    output logic [DWIDTH-1:0]   ALU_B,
    output logic                ALU_CIN,
    output logic                ALU_BIN,
    input  logic [DWIDTH-1:0]   ALU_OUT,
    input  logic                ALU_EN_C,
    input  logic                ALU_EN_B,
    input  logic                ALU_COUT,
    input  logic                ALU_BOUT,
    output logic [DWIDTH-1:0]   ACC,
    output logic                C_FLAG,
    output logic                B_FLAG,
    output logic                Z_FLAG,
    output logic                ILLEGAL
);
    localparam int unsigned IWIDTH = AWIDTH + 4;

    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_NOP  = 4'hC;
    localparam logic [3:0] OP_RST  = 4'hD;
    localparam logic [3:0] OP_ILL  = 4'hE;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    state_e              state;
    state_e              state_nxt;
    logic [IWIDTH-1:0]   ir;
    logic [IWIDTH-1:0]   ir_nxt;
    logic [DWIDTH-1:0]   opnd;
    logic [DWIDTH-1:0]   opnd_nxt;
    logic [DWIDTH-1:0]   acc;
    logic [DWIDTH-1:0]   acc_nxt;
    logic                c_flag;
    logic                c_nxt;
    logic                b_flag;
    logic                b_nxt;
    logic                illegal;
    logic                ill_nxt;

    logic                ready_q;
    logic                done_q;
    logic                re_q;
    logic                we_q;
    logic                cin_q;
    logic                bin_q;
    logic [3:0]          alu_instr_q;
    logic                ready_nxt;
    logic                done_nxt;
    logic                re_nxt;
    logic                we_nxt;
    logic                cin_nxt;
    logic                bin_nxt;
    logic [3:0]          alu_instr_nxt;

    logic [3:0]          ir_op;
    logic [3:0]          in_op;
    logic [3:0]          nxt_op;
    logic                accept;

    assign ir_op  = ir[IWIDTH-1 -: 4];
    assign in_op  = INSTR[IWIDTH-1 -: 4];
    assign nxt_op = ir_nxt[IWIDTH-1 -: 4];
    assign accept = INSTR_VALID && ready_q;

    function automatic logic is_mem_op(input logic [3:0] op);
        return ((op >= 4'h1) && (op <= OP_ADD)) || (op == OP_LD);
    endfunction

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and architectural register updates
    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        opnd_nxt  = opnd;
        acc_nxt   = acc;
        c_nxt     = c_flag;
        b_nxt     = b_flag;
        ill_nxt   = illegal;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    ir_nxt = INSTR;
                    if (is_mem_op(in_op)) begin
                        state_nxt = S_READ;
                    end else if (in_op == OP_ST) begin
                        state_nxt = S_WRITE;
                    end else begin
                        state_nxt = S_EXEC;
                    end
                end
            end
            S_READ: begin
                opnd_nxt  = MEM_RDATA;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_IDLE;
                if (ir_op <= OP_LD) begin
                    acc_nxt = ALU_OUT;
                    if (ALU_EN_C) begin
                        c_nxt = ALU_COUT;
                    end
                    if (ALU_EN_B) begin
                        b_nxt = ALU_BOUT;
                    end
                end else if (ir_op == OP_RST) begin
                    acc_nxt = '0;
                    c_nxt   = 1'b0;
                    b_nxt   = 1'b0;
                end else if (ir_op >= OP_ILL) begin
                    ill_nxt = 1'b1;
                end
            end
            S_WRITE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake, strobe and ALU control values for the coming cycle
    always_comb begin
        ready_nxt     = 1'b0;
        done_nxt      = 1'b0;
        re_nxt        = 1'b0;
        we_nxt        = 1'b0;
        cin_nxt       = 1'b0;
        bin_nxt       = 1'b0;
        alu_instr_nxt = OP_NOP;
        case (state_nxt)
            S_IDLE:  ready_nxt = 1'b1;
            S_READ:  re_nxt    = 1'b1;
            S_EXEC: begin
                done_nxt      = 1'b1;
                alu_instr_nxt = nxt_op;
                cin_nxt       = (nxt_op == OP_ADD) && c_flag;
                bin_nxt       = (nxt_op == OP_SUB) && b_flag;
            end
            S_WRITE: begin
                done_nxt = 1'b1;
                we_nxt   = 1'b1;
            end
            default: ready_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ir          <= '0;
            opnd        <= '0;
            acc         <= '0;
            c_flag      <= 1'b0;
            b_flag      <= 1'b0;
            illegal     <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            cin_q       <= 1'b0;
            bin_q       <= 1'b0;
            alu_instr_q <= OP_NOP;
        end else begin
            ir          <= ir_nxt;
            opnd        <= opnd_nxt;
            acc         <= acc_nxt;
            c_flag      <= c_nxt;
            b_flag      <= b_nxt;
            illegal     <= ill_nxt;
            ready_q     <= ready_nxt;
            done_q      <= done_nxt;
            re_q        <= re_nxt;
            we_q        <= we_nxt;
            cin_q       <= cin_nxt;
            bin_q       <= bin_nxt;
            alu_instr_q <= alu_instr_nxt;
        end
    end

    assign INSTR_READY = ready_q;
    assign DONE        = done_q;
    assign MEM_RE      = re_q;
    assign MEM_WE      = we_q;
    assign MEM_ADDR    = ir[AWIDTH-1:0];
    assign MEM_WDATA   = acc;
    assign ALU_INSTR   = alu_instr_q;
    assign ALU_A       = acc;
    assign ALU_B       = opnd;
    assign ALU_CIN     = cin_q;
    assign ALU_BIN     = bin_q;
    assign ACC         = acc;
    assign C_FLAG      = c_flag;
    assign B_FLAG      = b_flag;
    assign Z_FLAG      = (acc == '0);
    assign ILLEGAL     = illegal;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: external ALU and memory models, an instruction-level
// reference model checked every cycle, directed scenarios and random traffic.
module tb_alu_exec_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       INSTR_VALID = 1'b0;
    logic       INSTR_READY;
    logic [7:0] INSTR = 8'h00;
    logic       DONE;
    logic [3:0] MEM_ADDR;
    logic       MEM_RE;
    logic [7:0] MEM_RDATA;
    logic       MEM_WE;
    logic [7:0] MEM_WDATA;
    logic [3:0] ALU_INSTR;
    logic [7:0] ALU_A;
    logic [7:0] ALU_B;
    logic       ALU_CIN;
    logic       ALU_BIN;
    logic [7:0] ALU_OUT;
    logic       ALU_EN_C;
    logic       ALU_EN_B;
    logic       ALU_COUT;
    logic       ALU_BOUT;
    logic [7:0] ACC;
    logic       C_FLAG;
    logic       B_FLAG;
    logic       Z_FLAG;
    logic       ILLEGAL;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alu_exec_ctrl #(.DWIDTH(8), .AWIDTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .INSTR(INSTR),
        .DONE(DONE),
        .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE), .MEM_RDATA(MEM_RDATA),
        .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA),
        .ALU_INSTR(ALU_INSTR), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_CIN(ALU_CIN), .ALU_BIN(ALU_BIN), .ALU_OUT(ALU_OUT),
        .ALU_EN_C(ALU_EN_C), .ALU_EN_B(ALU_EN_B),
        .ALU_COUT(ALU_COUT), .ALU_BOUT(ALU_BOUT),
        .ACC(ACC), .C_FLAG(C_FLAG), .B_FLAG(B_FLAG), .Z_FLAG(Z_FLAG),
        .ILLEGAL(ILLEGAL)
    );

    // Environment: data memory with read data available by the next edge
    logic [7:0] init_mem [16];
    logic [7:0] env_mem  [16];
    logic       do_init = 1'b0;
    int         we_count = 0;

    assign MEM_RDATA = env_mem[MEM_ADDR];

    always @(posedge CLK) begin
        if (do_init) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= init_mem[i];
        end else if (MEM_WE) begin
            env_mem[MEM_ADDR] <= MEM_WDATA;
        end
        if (MEM_WE) we_count <= we_count + 1;
    end

    // Environment: combinational ALU
    logic [8:0] alu_t;
    always_comb begin
        alu_t    = 9'h000;
        ALU_OUT  = ALU_A;
        ALU_EN_C = 1'b0;
        ALU_EN_B = 1'b0;
        ALU_COUT = 1'b0;
        ALU_BOUT = 1'b0;
        case (ALU_INSTR)
            4'h0: ALU_OUT = ~ALU_A;
            4'h1: ALU_OUT = ALU_A ^ ALU_B;
            4'h2: ALU_OUT = ALU_A | ALU_B;
            4'h3: ALU_OUT = ALU_A & ALU_B;
            4'h4: begin
                alu_t = {1'b0, ALU_A} - {1'b0, ALU_B} - 9'(ALU_BIN);
                ALU_OUT = alu_t[7:0]; ALU_BOUT = alu_t[8]; ALU_EN_B = 1'b1;
            end
            4'h5: begin
                alu_t = {1'b0, ALU_A} + {1'b0, ALU_B} + 9'(ALU_CIN);
                ALU_OUT = alu_t[7:0]; ALU_COUT = alu_t[8]; ALU_EN_C = 1'b1;
            end
            4'h6: ALU_OUT = {ALU_A[0], ALU_A[7:1]};
            4'h7: ALU_OUT = {ALU_A[6:0], ALU_A[7]};
            4'h8: begin
                alu_t = {1'b0, ALU_A} - 9'd1;
                ALU_OUT = alu_t[7:0]; ALU_BOUT = alu_t[8]; ALU_EN_B = 1'b1;
            end
            4'h9: begin
                alu_t = {1'b0, ALU_A} + 9'd1;
                ALU_OUT = alu_t[7:0]; ALU_COUT = alu_t[8]; ALU_EN_C = 1'b1;
            end
            4'hA: ALU_OUT = ALU_B;
            default: ALU_OUT = ALU_A;
        endcase
    end

    // Reference model: instruction-level, counting cycles until retirement
    int         m_remain = 0;
    int         n_acc = 0;
    logic [3:0] m_op = 4'h0;
    logic [3:0] m_addr = 4'h0;
    logic [7:0] m_acc = 8'h00;
    logic [7:0] m_opnd = 8'h00;
    logic       m_c = 1'b0;
    logic       m_b = 1'b0;
    logic       m_ill = 1'b0;
    logic [7:0] m_mem [16];

    function automatic bit needs_operand(input logic [3:0] op);
        return (op >= 4'h1 && op <= 4'h5) || op == 4'hA;
    endfunction

    task automatic retire();
        int t;
        case (m_op)
            4'h0: m_acc = ~m_acc;
            4'h1: m_acc = m_acc ^ m_opnd;
            4'h2: m_acc = m_acc | m_opnd;
            4'h3: m_acc = m_acc & m_opnd;
            4'h4: begin
                t = int'(m_acc) - int'(m_opnd) - int'(m_b);
                m_b = (t < 0); m_acc = 8'(t);
            end
            4'h5: begin
                t = int'(m_acc) + int'(m_opnd) + int'(m_c);
                m_c = (t > 255); m_acc = 8'(t);
            end
            4'h6: m_acc = {m_acc[0], m_acc[7:1]};
            4'h7: m_acc = {m_acc[6:0], m_acc[7]};
            4'h8: begin m_b = (m_acc == 8'h00); m_acc = m_acc - 8'd1; end
            4'h9: begin m_c = (m_acc == 8'hFF); m_acc = m_acc + 8'd1; end
            4'hA: m_acc = m_opnd;
            4'hB: m_mem[m_addr] = m_acc;
            4'hD: begin m_acc = 8'h00; m_c = 1'b0; m_b = 1'b0; end
            4'hE, 4'hF: m_ill = 1'b1;
            default: m_acc = m_acc;
        endcase
    endtask

    always @(posedge CLK) begin
        if (do_init) begin
            for (int i = 0; i < 16; i++) m_mem[i] = init_mem[i];
        end
        if (RST) begin
            m_remain = 0; m_acc = 8'h00; m_opnd = 8'h00;
            m_c = 1'b0; m_b = 1'b0; m_ill = 1'b0; m_op = 4'h0; m_addr = 4'h0;
        end else if (m_remain == 1) begin
            retire();
            m_remain = 0;
        end else if (m_remain == 2) begin
            m_opnd = m_mem[m_addr];
            m_remain = 1;
        end else if (INSTR_VALID) begin
            m_op = INSTR[7:4];
            m_addr = INSTR[3:0];
            m_remain = needs_operand(m_op) ? 2 : 1;
            n_acc++;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    bit started = 1'b0;
    always @(negedge CLK) begin
        if (started) begin
            logic       ex_exec;
            logic       ex_we;
            ex_exec = (m_remain == 1) && (m_op != 4'hB);
            ex_we   = (m_remain == 1) && (m_op == 4'hB);
            chk("ready", 8'(INSTR_READY), 8'(m_remain == 0));
            chk("done",  8'(DONE),        8'(m_remain == 1));
            chk("mem_re", 8'(MEM_RE),     8'(m_remain == 2));
            chk("mem_we", 8'(MEM_WE),     8'(ex_we));
            chk("alu_instr", 8'(ALU_INSTR), 8'(ex_exec ? m_op : 4'hC));
            chk("alu_cin", 8'(ALU_CIN), 8'(ex_exec && m_op == 4'h5 && m_c));
            chk("alu_bin", 8'(ALU_BIN), 8'(ex_exec && m_op == 4'h4 && m_b));
            chk("alu_a", ALU_A, m_acc);
            chk("alu_b", ALU_B, m_opnd);
            chk("acc", ACC, m_acc);
            chk("c_flag", 8'(C_FLAG), 8'(m_c));
            chk("b_flag", 8'(B_FLAG), 8'(m_b));
            chk("z_flag", 8'(Z_FLAG), 8'(m_acc == 8'h00));
            chk("illegal", 8'(ILLEGAL), 8'(m_ill));
            if (m_remain == 2 || ex_we) chk("mem_addr", 8'(MEM_ADDR), 8'(m_addr));
            if (ex_we) chk("mem_wdata", MEM_WDATA, m_acc);
        end
    end

    task automatic sync_drive();
        @(posedge CLK);
        #1;
    endtask

    // Present an instruction and return just after the edge that accepts it
    task automatic issue(input logic [7:0] ins, input bit hold);
        int n;
        INSTR = ins;
        INSTR_VALID = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!INSTR_READY && n < 50);
        if (!INSTR_READY) begin
            errors++;
            $display("FAIL accept_timeout got=busy exp=ready instr=%h", ins);
        end
        sync_drive();
        if (!hold) INSTR_VALID = 1'b0;
    endtask

    // Wait (at negedges) until the model has retired everything in flight
    task automatic wait_retire();
        int n;
        n = 0;
        while (m_remain != 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (m_remain != 0) begin
            errors++;
            $display("FAIL retire_timeout got=%0d exp=0", m_remain);
        end
    endtask

    task automatic run(input logic [7:0] ins);
        issue(ins, 1'b0);
        wait_retire();
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        sync_drive();
        RST = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_before;
        int acc_before;
        for (int i = 0; i < 16; i++) init_mem[i] = 8'($urandom);
        init_mem[0] = 8'hFF;
        init_mem[3] = 8'h01;
        init_mem[5] = 8'h01;
        init_mem[6] = 8'hA5;
        do_init = 1'b1;
        sync_drive();
        do_init = 1'b0;
        started = 1'b1;
        sync_drive();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_ready", 8'(INSTR_READY), 8'd1);
        chk("rst_acc", ACC, 8'h00);
        chk("rst_strobes", 8'({DONE, MEM_RE, MEM_WE, ILLEGAL}), 8'd0);

        // Reset while the operand read is in progress
        sync_drive();
        we_before = we_count;
        issue(8'h53, 1'b0);
        pulse_reset();
        @(negedge CLK);
        chk("midrd_ready", 8'(INSTR_READY), 8'd1);
        chk("midrd_strobes", 8'({DONE, MEM_RE, MEM_WE}), 8'd0);
        chk("midrd_acc", ACC, 8'h00);
        sync_drive();
        sync_drive();
        chk("midrd_no_we", 8'(we_count - we_before), 8'd0);

        // ACC=FF, C=0, ADD mem[3]=01
        run(8'hA0);
        chk("ld_ff", ACC, 8'hFF);
        sync_drive();
        issue(8'h53, 1'b0);
        @(negedge CLK);
        chk("add_re", 8'(MEM_RE), 8'd1);
        chk("add_addr", 8'(MEM_ADDR), 8'h03);
        chk("add_done_early", 8'(DONE), 8'd0);
        @(negedge CLK);
        chk("add_done", 8'(DONE), 8'd1);
        wait_retire();
        chk("add_acc", ACC, 8'h00);
        chk("add_c", 8'(C_FLAG), 8'd1);
        chk("add_z", 8'(Z_FLAG), 8'd1);
        chk("model_add_acc", m_acc, 8'h00);
        sync_drive();

        // INC ignores the carry flag
        run(8'h90);
        chk("inc_acc", ACC, 8'h01);
        chk("inc_c", 8'(C_FLAG), 8'd0);
        sync_drive();

        // SUB then DEC
        run(8'hD0);
        chk("rst_op_acc", ACC, 8'h00);
        sync_drive();
        run(8'h45);
        chk("sub_acc", ACC, 8'hFF);
        chk("sub_b", 8'(B_FLAG), 8'd1);
        chk("model_sub_acc", m_acc, 8'hFF);
        sync_drive();
        run(8'h80);
        chk("dec_acc", ACC, 8'hFE);
        chk("dec_b", 8'(B_FLAG), 8'd0);
        sync_drive();

        // Store A5 to address 7
        run(8'hA6);
        sync_drive();
        we_before = we_count;
        issue(8'hB7, 1'b0);
        @(negedge CLK);
        chk("st_we", 8'(MEM_WE), 8'd1);
        chk("st_addr", 8'(MEM_ADDR), 8'h07);
        chk("st_data", MEM_WDATA, 8'hA5);
        wait_retire();
        sync_drive();
        @(negedge CLK);
        chk("st_we_once", 8'(we_count - we_before), 8'd1);
        chk("st_mem", env_mem[7], 8'hA5);
        chk("st_acc", ACC, 8'hA5);
        sync_drive();

        // Back-to-back with VALID held high; ILLEGAL and RST behaviour
        run(8'hA0);
        sync_drive();
        run(8'h90);
        sync_drive();
        run(8'h45);
        sync_drive();
        acc_before = n_acc;
        issue(8'hF3, 1'b1);
        issue(8'hC0, 1'b1);
        chk("ill_acc", ACC, 8'hFF);
        chk("ill_flags", 8'({C_FLAG, B_FLAG}), 8'd3);
        chk("ill_set", 8'(ILLEGAL), 8'd1);
        issue(8'hD0, 1'b0);
        wait_retire();
        chk("b2b_count", 8'(n_acc - acc_before), 8'd3);
        chk("rstop_acc", ACC, 8'h00);
        chk("rstop_flags", 8'({C_FLAG, B_FLAG}), 8'd0);
        chk("rstop_ill", 8'(ILLEGAL), 8'd1);
        sync_drive();

        // Random traffic with occasional mid-instruction resets
        for (int k = 0; k < 400; k++) begin
            logic [7:0] ins;
            ins = 8'($urandom);
            if ($urandom_range(0, 9) < 2) ins[7:4] = 4'hA;
            issue(ins, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 1) == 1) sync_drive();
                pulse_reset();
            end
            if ($urandom_range(0, 3) == 0) begin
                INSTR_VALID = 1'b0;
                sync_drive();
            end
        end
        INSTR_VALID = 1'b0;
        wait_retire();
        sync_drive();
        @(negedge CLK);
        for (int i = 0; i < 16; i++) chk("final_mem", env_mem[i], m_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
